// File: rtl/riscv_div.sv
// riscv_div: RV32M divider (DIV/DIVU/REM/REMU) built on radix-2 restoring division.
// One quotient bit per cycle for 32 cycles, then one sign-correction cycle.
// Divide-by-zero and signed overflow resolve at accept time and reach DONE one edge later.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready request handshake; in_ready = unit idle
//   op                  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1, rs2            dividend, divisor
//   out_valid/out_ready result handshake; rd holds quotient or remainder
//   flush               synchronous abort of any in-flight operation
module riscv_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  input  logic             flush
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic           is_rem_q;
  logic           neg_quo_q;
  logic           neg_rem_q;
  logic           special_q;
  logic [W-1:0]   dvsr_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   rem_q;
  logic [CW-1:0]  cnt_q;

  logic           accept;
  logic           is_signed;
  logic           rs1_neg, rs2_neg;
  logic [W-1:0]   rs1_abs, rs2_abs;
  logic           div_zero, overflow, special;
  logic [W-1:0]   special_val;
  logic [W:0]     rem_shift, diff;
  logic [W-1:0]   quo_fix, rem_fix, result;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Operand conditioning at accept: magnitudes, result signs and the corner cases
  always_comb begin
    is_signed   = ~op[0];
    rs1_neg     = is_signed & rs1[W-1];
    rs2_neg     = is_signed & rs2[W-1];
    rs1_abs     = rs1_neg ? W'(W'(0) - rs1) : rs1;
    rs2_abs     = rs2_neg ? W'(W'(0) - rs2) : rs2;
    div_zero    = (rs2 == '0);
    overflow    = is_signed && (rs1 == {1'b1, {(W-1){1'b0}}}) && (rs2 == '1);
    special     = div_zero | overflow;
    special_val = '0;
    if (div_zero) begin
      special_val = op[1] ? rs1 : '1;
    end else begin
      // signed overflow: quotient is the most negative value, remainder zero
      special_val = op[1] ? '0 : rs1;
    end
  end

  // One restoring step: shift next dividend bit into the partial remainder, trial subtract
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    diff      = rem_shift - {1'b0, dvsr_q};
  end

  // Sign correction and result select for the FIX cycle
  always_comb begin
    quo_fix = neg_quo_q ? W'(W'(0) - quo_q) : quo_q;
    rem_fix = neg_rem_q ? W'(W'(0) - rem_q) : rem_q;
    result  = special_q ? rem_q : (is_rem_q ? rem_fix : quo_fix);
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? FIX : CALC;
      CALC: if (cnt_q == CW'(W - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      dvsr_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      rd        <= '0;
    end else begin
      if (accept) begin
        is_rem_q  <= op[1];
        neg_quo_q <= rs1_neg ^ rs2_neg;
        neg_rem_q <= rs1_neg;
        special_q <= special;
        dvsr_q    <= rs2_abs;
        // dividend shifts out of the top of quo_q while quotient bits enter at the bottom
        quo_q     <= rs1_abs;
        // special cases park their final answer in rem_q
        rem_q     <= special ? special_val : '0;
        cnt_q     <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CW'(1);
        quo_q <= {quo_q[W-2:0], ~diff[W]};
        rem_q <= diff[W] ? rem_shift[W-1:0] : diff[W-1:0];
      end
      out_valid <= (state_d == DONE);
      if (state_q == FIX && state_d == DONE) rd <= result;
    end
  end

endmodule

// File: tb/tb_riscv_div.sv
// tb_riscv_div: self-checking bench for riscv_div with a plain-arithmetic reference model.
module tb_riscv_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rd;
  logic        flush = 1'b0;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  riscv_div #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .rd(rd), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference: RV32M division semantics from plain arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    if (!f[0]) return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    return f[1] ? a % b : a / b;
  endfunction

  function automatic int ref_latency(input logic [1:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request for one edge (caller ensures the unit is idle)
  task automatic start(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    op       = f;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    op = OP_DIV; rs1 = 32'd9; rs2 = 32'd3;
    tick(3);
    checks++;
    if (out_valid !== 1'b0 || rd !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b rd=%h in_ready=%b, want 0 00000000 1",
               out_valid, rd, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    // first edge after deassert must accept
    begin
      int lat;
      start(OP_DIV, 32'd100, 32'd7);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL first_edge_accept: in_ready=%b want 0", in_ready);
      end
      wait_done(lat);
      checks++;
      if (rd !== 32'd14 || lat != 33) begin
        errors++;
        $display("FAIL div_100_7: rd=%h lat=%0d want 0000000e lat=33", rd, lat);
      end
      consume();
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [10] = '{OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_DIVU, OP_REMU,
                                OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] t_a   [10] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
    logic [31:0] t_b   [10] = '{32'd7, 32'd2, 32'd2, 32'd1, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] t_exp [10] = '{32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    int          t_lat [10] = '{33, 33, 33, 33, 1, 1, 1, 1, 1, 1};
    int lat;
    for (int i = 0; i < 10; i++) begin
      start(t_op[i], t_a[i], t_b[i]);
      wait_done(lat);
      checks++;
      if (rd !== t_exp[i] || lat != t_lat[i]) begin
        errors++;
        $display("FAIL directed_%0d: op=%0d rs1=%h rs2=%h rd=%h lat=%0d want %h lat=%0d",
                 i, t_op[i], t_a[i], t_b[i], rd, lat, t_exp[i], t_lat[i]);
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] a, b;
    logic [1:0]  f;
    int lat;
    for (int i = 0; i < 60; i++) begin
      f = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 3))
        0:       b = corner[$urandom_range(0, 4)];
        1:       b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      start(f, a, b);
      wait_done(lat);
      checks++;
      if (rd !== ref_result(f, a, b) || lat != ref_latency(f, a, b)) begin
        errors++;
        $display("FAIL random_%0d: op=%0d rs1=%h rs2=%h rd=%h lat=%0d want %h lat=%0d",
                 i, f, a, b, rd, lat, ref_result(f, a, b), ref_latency(f, a, b));
      end
      tick($urandom_range(0, 2));
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bad;
    start(OP_DIV, 32'hFFFF_FF9C, 32'd7);   // -100 / 7 = -14
    wait_done(lat);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || rd !== 32'hFFFF_FFF2 || in_ready !== 1'b0) bad = 1'b1;
      tick(1);
    end
    checks++;
    if (bad || lat != 33) begin
      errors++;
      $display("FAIL hold_in_done: out_valid=%b rd=%h in_ready=%b lat=%0d want 1 fffffff2 0 33",
               out_valid, rd, in_ready, lat);
    end
    // consume while a new request waits: it must not be taken on the consume edge
    op = OP_REMU; rs1 = 32'd1000; rs2 = 32'd33; in_valid = 1'b1;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_accept_on_consume: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    tick(1);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_after_consume: in_ready=%b want 0", in_ready);
    end
    wait_done(lat);
    checks++;
    if (rd !== 32'd10 || lat != 33) begin
      errors++;
      $display("FAIL second_result: rd=%h lat=%0d want 0000000a lat=33", rd, lat);
    end
    consume();
  endtask

  task automatic test_flush();
    int lat;
    logic seen;
    // flush at CALC cycle 10
    start(OP_DIV, 32'd1234, 32'd10);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick(1);
    end
    checks++;
    if (seen || rd !== 32'd10) begin
      errors++;
      $display("FAIL flush_no_result: out_valid_seen=%b rd=%h want 0 0000000a", seen, rd);
    end
    // flush beats in_valid in idle
    op = OP_DIVU; rs1 = 32'd50; rs2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
    tick(1);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_blocks_accept: in_ready=%b want 1", in_ready);
    end
    start(OP_DIV, 32'd1234, 32'd10);
    wait_done(lat);
    checks++;
    if (rd !== 32'd123 || lat != 33) begin
      errors++;
      $display("FAIL after_flush: rd=%h lat=%0d want 0000007b lat=33", rd, lat);
    end
    // flush in DONE drops out_valid and keeps rd
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd !== 32'd123) begin
      errors++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b rd=%h want 0 1 0000007b",
               out_valid, in_ready, rd);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    start(OP_REM, 32'd999, 32'd8);
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rd !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b rd=%h in_ready=%b want 0 00000000 1",
               out_valid, rd, in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick(1);
    end
    checks++;
    if (seen || rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_result: out_valid_seen=%b rd=%h want 0 00000000", seen, rd);
    end
    start(OP_REM, 32'd999, 32'd8);
    wait_done(lat);
    checks++;
    if (rd !== 32'd7 || lat != 33) begin
      errors++;
      $display("FAIL after_reset: rd=%h lat=%0d want 00000007 lat=33", rd, lat);
    end
    consume();
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
